// File: rtl/riscv_pkg.sv
// Shared core package: branch-compare FSM encodings and default compare slice width.
package riscv_pkg;

  localparam int unsigned BRCMP_CHUNK_DEFAULT = 8;

  typedef enum logic [0:0] {
    BRCMP_IDLE = 1'b0,
    BRCMP_RUN  = 1'b1
  } brcmp_state_t;

endpackage

// File: rtl/brcmp_chunk.sv
// Combinational unsigned compare of one operand slice.
module brcmp_chunk #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         lt
);

  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/branch_compare_seq.sv
// Iterative BrEq/BrLT comparator, one CHUNK-bit slice per cycle, MSB slice first.
// Optional build macro: BRCMP_EARLY_EXIT_EN (stop at the first differing slice).
module branch_compare_seq
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CHUNK = BRCMP_CHUNK_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] RS1,
  input  logic [XLEN-1:0] RS2,
  input  logic            BrUn,
  output logic            busy,
  output logic            done,
  output logic            BrEq,
  output logic            BrLT
);

  localparam int unsigned N    = XLEN / CHUNK;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned NPOW = 1 << IDXW;
  localparam logic [XLEN-1:0] SIGN_BIT = {1'b1, {(XLEN-1){1'b0}}};

  if ((CHUNK == 0) || (XLEN % CHUNK != 0)) begin : g_bad_chunk
    $error("branch_compare_seq: CHUNK must divide XLEN");
  end

  brcmp_state_t    state, state_nxt;
  logic [XLEN-1:0] a, b;
  logic [IDXW-1:0] idx;
  logic            diff_found, lt_found;
  logic            chunk_eq, chunk_lt, last_c, accept_c;
  logic            busy_nxt, done_nxt, eq_nxt, lt_nxt;
  logic [CHUNK-1:0] a_ch [NPOW];
  logic [CHUNK-1:0] b_ch [NPOW];

  // Slice table indexed by idx; padding entries keep the index fully decoded.
  for (genvar i = 0; i < NPOW; i++) begin : g_ch
    if (i < N) begin : g_real
      assign a_ch[i] = a[i*CHUNK +: CHUNK];
      assign b_ch[i] = b[i*CHUNK +: CHUNK];
    end else begin : g_pad
      assign a_ch[i] = '0;
      assign b_ch[i] = '0;
    end
  end

  brcmp_chunk #(.W(CHUNK)) u_chunk (
    .a  (a_ch[idx]),
    .b  (b_ch[idx]),
    .eq (chunk_eq),
    .lt (chunk_lt)
  );

`ifdef BRCMP_EARLY_EXIT_EN
  assign last_c = (state == BRCMP_RUN) && ((idx == '0) || !chunk_eq);
`else
  assign last_c = (state == BRCMP_RUN) && (idx == '0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= BRCMP_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      BRCMP_IDLE: if (start)  state_nxt = BRCMP_RUN;
      BRCMP_RUN:  if (last_c) state_nxt = BRCMP_IDLE;
      default:                state_nxt = BRCMP_IDLE;
    endcase
  end

  // Output/next-value logic; an earlier differing slice always dominates.
  always_comb begin
    accept_c = 1'b0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    eq_nxt   = BrEq;
    lt_nxt   = BrLT;
    case (state)
      BRCMP_IDLE: begin
        accept_c = start;
        busy_nxt = start;
      end
      BRCMP_RUN: begin
        busy_nxt = !last_c;
        done_nxt = last_c;
        if (last_c) begin
          if (diff_found) begin
            eq_nxt = 1'b0;
            lt_nxt = lt_found;
          end else begin
            eq_nxt = chunk_eq;
            lt_nxt = chunk_lt;
          end
        end
      end
      default: ;
    endcase
  end

  // Operand/index/result registers; signed mode biases the sign bit to compare unsigned.
  always_ff @(posedge clk) begin
    if (rst) begin
      a          <= '0;
      b          <= '0;
      idx        <= '0;
      diff_found <= 1'b0;
      lt_found   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      BrEq       <= 1'b0;
      BrLT       <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      BrEq <= eq_nxt;
      BrLT <= lt_nxt;
      if (accept_c) begin
        a          <= RS1 ^ (BrUn ? '0 : SIGN_BIT);
        b          <= RS2 ^ (BrUn ? '0 : SIGN_BIT);
        idx        <= IDXW'(N - 1);
        diff_found <= 1'b0;
        lt_found   <= 1'b0;
      end else if (state == BRCMP_RUN) begin
        if (!diff_found && !chunk_eq) begin
          diff_found <= 1'b1;
          lt_found   <= chunk_lt;
        end
        if (!last_c) idx <= idx - IDXW'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_compare_seq.sv
// Self-checking bench for branch_compare_seq against a plain-arithmetic reference model.
// Honors BRCMP_EARLY_EXIT_EN for the expected latency.
module tb_branch_compare_seq;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CHUNK = 8;
  localparam int unsigned N     = XLEN / CHUNK;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [XLEN-1:0] RS1, RS2;
  logic            BrUn;
  logic            busy, done, BrEq, BrLT;

  int checks = 0;
  int fails  = 0;

  branch_compare_seq #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .RS1   (RS1),
    .RS2   (RS2),
    .BrUn  (BrUn),
    .busy  (busy),
    .done  (done),
    .BrEq  (BrEq),
    .BrLT  (BrLT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_eq(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    return x == y;
  endfunction

  function automatic logic ref_lt(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                                  input logic un);
    if (un) return x < y;
    return $signed(x) < $signed(y);
  endfunction

  // Cycles from accepted start to done.
  function automatic int ref_lat(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
`ifdef BRCMP_EARLY_EXIT_EN
    logic [XLEN-1:0] d;
    d = x ^ y;
    for (int j = 0; j < int'(N); j++)
      if (d[XLEN-1-j*CHUNK -: CHUNK] != '0) return j + 2;
`endif
    return N + 1;
  endfunction

  // Start at the next negedge, then check busy/done each cycle up to done.
  task automatic run_cmp(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                         input logic un, input string tag);
    int lat;
    lat = ref_lat(x, y);
    @(negedge clk);
    start = 1'b1; RS1 = x; RS2 = y; BrUn = un;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      start = 1'b0; RS1 = $urandom; RS2 = $urandom; BrUn = 1'($urandom);
      chk({tag, ".busy"}, 32'(busy), 32'(k < lat));
      chk({tag, ".done"}, 32'(done), 32'(k == lat));
    end
    chk({tag, ".BrEq"}, 32'(BrEq), 32'(ref_eq(x, y)));
    chk({tag, ".BrLT"}, 32'(BrLT), 32'(ref_lt(x, y, un)));
    @(negedge clk);
    chk({tag, ".done_once"}, 32'(done), 32'(0));
    chk({tag, ".held_eq"}, 32'(BrEq), 32'(ref_eq(x, y)));
  endtask

  initial begin
    logic [XLEN-1:0] x, y;
    logic            un;
    int              lat_a, lat_b;
    int              dones;

    rst = 1'b1; start = 1'b0; RS1 = '0; RS2 = '0; BrUn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.busy", 32'(busy), 32'(0));
    chk("reset.done", 32'(done), 32'(0));
    chk("reset.BrEq", 32'(BrEq), 32'(0));
    chk("reset.BrLT", 32'(BrLT), 32'(0));
    rst = 1'b0;

    // Directed cases
    run_cmp(32'd5, 32'd5, 1'b0, "eq5");
    run_cmp(32'hFFFF_FFFF, 32'd1, 1'b0, "neg1_s");
    run_cmp(32'hFFFF_FFFF, 32'd1, 1'b1, "neg1_u");
    run_cmp(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, "min_max_s");
    run_cmp(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, "min_max_u");
    run_cmp(32'h1234_5600, 32'h1234_5601, 1'b1, "lsb_diff");
    run_cmp(32'h1234_5601, 32'h1234_5600, 1'b0, "lsb_diff_gt");
    run_cmp(32'h0000_0000, 32'h8000_0000, 1'b0, "zero_vs_min");

    // Randomized, biased toward shared upper slices to spread the first difference.
    for (int n = 0; n < 60; n++) begin
      x = $urandom; y = $urandom; un = 1'($urandom);
      case ($urandom_range(0, 3))
        0: y = x;
        1: y = (x & 32'hFFFF_FF00) | (y & 32'h0000_00FF);
        2: y = (x & 32'hFFFF_0000) | (y & 32'h0000_FFFF);
        default: ;
      endcase
      run_cmp(x, y, un, $sformatf("rnd%0d", n));
    end

    // start held high during RUN is ignored; start in the done cycle is accepted.
    lat_a = ref_lat(32'd5, 32'd5);
    lat_b = ref_lat(32'h1234_5600, 32'h1234_5601);
    @(negedge clk);
    start = 1'b1; RS1 = 32'd5; RS2 = 32'd5; BrUn = 1'b0;
    for (int k = 1; k <= lat_a; k++) begin
      @(negedge clk);
      if (k < lat_a) begin
        RS1 = $urandom; RS2 = $urandom; BrUn = 1'($urandom);
      end else begin
        RS1 = 32'h1234_5600; RS2 = 32'h1234_5601; BrUn = 1'b1;
      end
      chk("hs1.busy", 32'(busy), 32'(k < lat_a));
      chk("hs1.done", 32'(done), 32'(k == lat_a));
    end
    chk("hs1.BrEq", 32'(BrEq), 32'(1));
    chk("hs1.BrLT", 32'(BrLT), 32'(0));
    for (int k = 1; k <= lat_b; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk("hs2.busy", 32'(busy), 32'(k < lat_b));
      chk("hs2.done", 32'(done), 32'(k == lat_b));
    end
    chk("hs2.BrEq", 32'(BrEq), 32'(0));
    chk("hs2.BrLT", 32'(BrLT), 32'(1));

    // Leave flags at eq=1, then abort a compare with reset in T+2.
    run_cmp(32'hCAFE_0001, 32'hCAFE_0001, 1'b1, "pre_abort");
    @(negedge clk);
    start = 1'b1; RS1 = 32'h0000_0001; RS2 = 32'h0000_0002; BrUn = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort.busy_T1", 32'(busy), 32'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", 32'(busy), 32'(0));
    chk("abort.done", 32'(done), 32'(0));
    chk("abort.BrEq", 32'(BrEq), 32'(0));
    chk("abort.BrLT", 32'(BrLT), 32'(0));
    dones = 0;
    for (int k = 0; k < 2 * int'(N) + 2; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort.no_done", 32'(dones), 32'(0));
    chk("abort.idle_busy", 32'(busy), 32'(0));

    // Normal operation resumes after the abort.
    run_cmp(32'h8000_0000, 32'h0000_0000, 1'b0, "post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
